stream_fork: RTL and testbench

- Broadcasts one AXI-Stream channel to two downstream AXI-Stream channels, the counterpart of a point-to-point join.
- Every accepted input beat is delivered exactly once on each output, and each output handshakes independently.
- Outputs are driven from a one-beat holding register, so no output's t_valid or payload depends combinationally on the input.
- Sits where a single producer feeds two consumers, e.g. a DMA stream mirrored to a checker.

---
 rtl/stream_fork_pkg.sv | 29 ++
 rtl/stream_channel.sv | 37 +++
 rtl/stream_fork.sv | 122 ++++++++++++
 tb/tb_stream_fork.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fork_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_fork_pkg                                                |
// | Brief   : Shared stream types and constants for the stream fork.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package stream_fork_pkg;

    localparam int c_id_width    = 4;
    localparam int c_data_width  = 32;
    localparam int c_dest_width  = 4;
    localparam int c_user_width  = 4;
    localparam int c_num_outputs = 2;

    localparam logic [c_num_outputs-1:0] c_pending_all  = '1;
    localparam logic [c_num_outputs-1:0] c_pending_none = '0;

    typedef struct packed {
        logic [c_id_width-1:0]     id;
        logic [c_dest_width-1:0]   dest;
        logic [c_data_width-1:0]   data;
        logic [c_data_width/8-1:0] strb;
        logic [c_data_width/8-1:0] keep;
        logic                      last;
        logic [c_user_width-1:0]   user;
    } stream_beat_t;

endpackage
`default_nettype wire

// File: rtl/stream_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_channel                                                 |
// | Brief   : AXI-Stream channel bundle with master and slave views.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface stream_channel
    import stream_fork_pkg::*;
#(
    parameter int ID_WIDTH   = c_id_width,
    parameter int DATA_WIDTH = c_data_width,
    parameter int DEST_WIDTH = c_dest_width,
    parameter int USER_WIDTH = c_user_width
) ();

    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [USER_WIDTH-1:0]   t_user;
    logic                    t_valid;
    logic                    t_ready;

    modport master (
        output t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user, t_valid,
        input  t_ready
    );

    modport slave (
        input  t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user, t_valid,
        output t_ready
    );

endinterface
`default_nettype wire

// File: rtl/stream_fork.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_fork                                                    |
// | Brief   : Broadcasts one AXI-Stream to two outputs via a one-beat hold  |
// |           register; each output handshakes independently.              |
// |           Optional beat/packet counters: define STREAM_FORK_STATS_EN.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module stream_fork
    import stream_fork_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    stream_channel.slave  master,
    stream_channel.master slave0,
    stream_channel.master slave1
`ifdef STREAM_FORK_STATS_EN
    ,
    output logic [31:0]   pkt_count,
    output logic [31:0]   beat_count
`endif
);

    localparam int c_id_w   = master.ID_WIDTH;
    localparam int c_data_w = master.DATA_WIDTH;
    localparam int c_dest_w = master.DEST_WIDTH;
    localparam int c_user_w = master.USER_WIDTH;

    if (c_id_w   != slave0.ID_WIDTH   || c_id_w   != slave1.ID_WIDTH   ||
        c_data_w != slave0.DATA_WIDTH || c_data_w != slave1.DATA_WIDTH ||
        c_dest_w != slave0.DEST_WIDTH || c_dest_w != slave1.DEST_WIDTH ||
        c_user_w != slave0.USER_WIDTH || c_user_w != slave1.USER_WIDTH) begin : g_width_mismatch
        $fatal(1, "stream_fork: stream_channel widths differ between ports");
    end

    typedef struct packed {
        logic [c_id_w-1:0]     id;
        logic [c_dest_w-1:0]   dest;
        logic [c_data_w-1:0]   data;
        logic [c_data_w/8-1:0] strb;
        logic [c_data_w/8-1:0] keep;
        logic                  last;
        logic [c_user_w-1:0]   user;
    } beat_t;

    beat_t                    r_hold;
    logic                     r_hold_valid;
    logic [c_num_outputs-1:0] r_pending;

    beat_t                    w_in_beat;
    logic [c_num_outputs-1:0] w_fire;
    logic                     w_done;
    logic                     w_fire_in;

    assign w_in_beat = '{id: master.t_id, dest: master.t_dest, data: master.t_data,
                         strb: master.t_strb, keep: master.t_keep,
                         last: master.t_last, user: master.t_user};

    assign w_fire    = {slave1.t_valid & slave1.t_ready, slave0.t_valid & slave0.t_ready};
    assign w_done    = r_hold_valid & ((r_pending & ~w_fire) == c_pending_none);

    // Gated by rstn so the producer sees no readiness while the block is held in reset.
    assign master.t_ready = rstn & (~r_hold_valid | w_done);
    assign w_fire_in      = master.t_valid & master.t_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_pending    <= c_pending_none;
        end else if (w_fire_in) begin
            r_hold       <= w_in_beat;
            r_hold_valid <= 1'b1;
            r_pending    <= c_pending_all;
        end else if (w_done) begin
            r_hold_valid <= 1'b0;
            r_pending    <= c_pending_none;
        end else begin
            r_pending    <= r_pending & ~w_fire;
        end
    end

    assign slave0.t_valid = r_hold_valid & r_pending[0];
    assign slave0.t_id    = r_hold.id;
    assign slave0.t_dest  = r_hold.dest;
    assign slave0.t_data  = r_hold.data;
    assign slave0.t_strb  = r_hold.strb;
    assign slave0.t_keep  = r_hold.keep;
    assign slave0.t_last  = r_hold.last;
    assign slave0.t_user  = r_hold.user;

    assign slave1.t_valid = r_hold_valid & r_pending[1];
    assign slave1.t_id    = r_hold.id;
    assign slave1.t_dest  = r_hold.dest;
    assign slave1.t_data  = r_hold.data;
    assign slave1.t_strb  = r_hold.strb;
    assign slave1.t_keep  = r_hold.keep;
    assign slave1.t_last  = r_hold.last;
    assign slave1.t_user  = r_hold.user;

`ifdef STREAM_FORK_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_beat_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pkt_count  <= '0;
            r_beat_count <= '0;
        end else if (w_fire_in) begin
            r_beat_count <= r_beat_count + 32'd1;
            if (master.t_last) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign beat_count = r_beat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fork.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_stream_fork                                                 |
// | Brief   : Self-checking bench for stream_fork with a queue scoreboard.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_stream_fork;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] dest;
        logic [7:0] data;
        logic       strb;
        logic       keep;
        logic       last;
        logic [2:0] user;
    } tb_beat_t;

    logic clk;
    logic rstn;

    stream_channel #(.ID_WIDTH(4), .DATA_WIDTH(8), .DEST_WIDTH(2), .USER_WIDTH(3)) m_if ();
    stream_channel #(.ID_WIDTH(4), .DATA_WIDTH(8), .DEST_WIDTH(2), .USER_WIDTH(3)) s0_if ();
    stream_channel #(.ID_WIDTH(4), .DATA_WIDTH(8), .DEST_WIDTH(2), .USER_WIDTH(3)) s1_if ();

`ifdef STREAM_FORK_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] beat_count;
`endif

    stream_fork dut (
        .clk    (clk),
        .rstn   (rstn),
        .master (m_if),
        .slave0 (s0_if),
        .slave1 (s1_if)
`ifdef STREAM_FORK_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .beat_count (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_del0  = 0;
    int n_del1  = 0;
    tb_beat_t q0[$];
    tb_beat_t q1[$];

    function automatic tb_beat_t make_beat(input int i);
        tb_beat_t b;
        b.id   = i[3:0];
        b.dest = i[5:4];
        b.data = i[7:0];
        b.strb = 1'b1;
        b.keep = 1'b1;
        b.last = (i[1:0] == 2'd3);
        b.user = i[10:8];
        return b;
    endfunction

    task automatic drive(input tb_beat_t b);
        m_if.t_id   = b.id;
        m_if.t_dest = b.dest;
        m_if.t_data = b.data;
        m_if.t_strb = b.strb;
        m_if.t_keep = b.keep;
        m_if.t_last = b.last;
        m_if.t_user = b.user;
    endtask

    // Scoreboard: outputs are popped before the same-edge input beat is pushed.
    always @(negedge clk) begin
        if (rstn) begin
            if (s0_if.t_valid && s0_if.t_ready) begin
                tb_beat_t g;
                tb_beat_t e;
                g = {s0_if.t_id, s0_if.t_dest, s0_if.t_data, s0_if.t_strb,
                     s0_if.t_keep, s0_if.t_last, s0_if.t_user};
                n_total++;
                n_del0++;
                if (q0.size() == 0) begin
                    $display("FAIL sb_slave0_unexpected got %h expected no beat", g);
                end else begin
                    e = q0.pop_front();
                    if (g !== e) $display("FAIL sb_slave0 got %h expected %h", g, e);
                    else n_pass++;
                end
            end
            if (s1_if.t_valid && s1_if.t_ready) begin
                tb_beat_t g;
                tb_beat_t e;
                g = {s1_if.t_id, s1_if.t_dest, s1_if.t_data, s1_if.t_strb,
                     s1_if.t_keep, s1_if.t_last, s1_if.t_user};
                n_total++;
                n_del1++;
                if (q1.size() == 0) begin
                    $display("FAIL sb_slave1_unexpected got %h expected no beat", g);
                end else begin
                    e = q1.pop_front();
                    if (g !== e) $display("FAIL sb_slave1 got %h expected %h", g, e);
                    else n_pass++;
                end
            end
            if (m_if.t_valid && m_if.t_ready) begin
                tb_beat_t b;
                b = {m_if.t_id, m_if.t_dest, m_if.t_data, m_if.t_strb,
                     m_if.t_keep, m_if.t_last, m_if.t_user};
                q0.push_back(b);
                q1.push_back(b);
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (s0_if.t_valid !== 1'b0) $display("FAIL rst_s0_valid got %b expected 0", s0_if.t_valid);
        else n_pass++;
        n_total++;
        if (s1_if.t_valid !== 1'b0) $display("FAIL rst_s1_valid got %b expected 0", s1_if.t_valid);
        else n_pass++;
        n_total++;
        if (m_if.t_ready !== 1'b0) $display("FAIL rst_m_ready got %b expected 0", m_if.t_ready);
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        n_total++;
        if (m_if.t_ready !== 1'b1) $display("FAIL rel_m_ready got %b expected 1", m_if.t_ready);
        else n_pass++;
        n_total++;
        if (s0_if.t_data !== 8'h00) $display("FAIL rel_s0_data got %h expected 00", s0_if.t_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [3];
        tb_beat_t b;
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h33;
        s0_if.t_ready = 1'b1;
        s1_if.t_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                b = make_beat(i);
                b.data = d[i];
                drive(b);
                m_if.t_valid = 1'b1;
            end else begin
                m_if.t_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 3) begin
                n_total++;
                if (m_if.t_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b expected 1", i, m_if.t_ready);
                else n_pass++;
            end
            if (i >= 1 && i <= 3) begin
                n_total++;
                if (s0_if.t_valid !== 1'b1 || s0_if.t_data !== d[i-1])
                    $display("FAIL b2b_s0[%0d] got v=%b d=%h expected v=1 d=%h", i, s0_if.t_valid, s0_if.t_data, d[i-1]);
                else n_pass++;
                n_total++;
                if (s1_if.t_valid !== 1'b1 || s1_if.t_data !== d[i-1])
                    $display("FAIL b2b_s1[%0d] got v=%b d=%h expected v=1 d=%h", i, s1_if.t_valid, s1_if.t_data, d[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_one_stalled();
        tb_beat_t b;
        s0_if.t_ready = 1'b1;
        s1_if.t_ready = 1'b0;
        @(posedge clk);
        #1;
        b = make_beat(1);
        b.data = 8'hAA;
        drive(b);
        m_if.t_valid = 1'b1;
        @(negedge clk);
        n_total++;
        if (m_if.t_ready !== 1'b1) $display("FAIL stl_accept_ready got %b expected 1", m_if.t_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        b = make_beat(2);
        b.data = 8'hBB;
        drive(b);
        @(negedge clk);
        n_total++;
        if (s0_if.t_valid !== 1'b1 || s0_if.t_data !== 8'hAA)
            $display("FAIL stl_s0_take got v=%b d=%h expected v=1 d=aa", s0_if.t_valid, s0_if.t_data);
        else n_pass++;
        n_total++;
        if (m_if.t_ready !== 1'b0) $display("FAIL stl_ready_c1 got %b expected 0", m_if.t_ready);
        else n_pass++;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n_total++;
            if (s0_if.t_valid !== 1'b0) $display("FAIL stl_s0_dropped[%0d] got %b expected 0", k, s0_if.t_valid);
            else n_pass++;
            n_total++;
            if (s1_if.t_valid !== 1'b1 || s1_if.t_data !== 8'hAA)
                $display("FAIL stl_s1_hold[%0d] got v=%b d=%h expected v=1 d=aa", k, s1_if.t_valid, s1_if.t_data);
            else n_pass++;
            n_total++;
            if (m_if.t_ready !== 1'b0) $display("FAIL stl_ready[%0d] got %b expected 0", k, m_if.t_ready);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        s1_if.t_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (m_if.t_ready !== 1'b1) $display("FAIL stl_release_ready got %b expected 1", m_if.t_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        m_if.t_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (s0_if.t_valid !== 1'b1 || s0_if.t_data !== 8'hBB || s1_if.t_valid !== 1'b1 || s1_if.t_data !== 8'hBB)
            $display("FAIL stl_next_beat got v0=%b d0=%h v1=%b d1=%h expected 1 bb 1 bb",
                     s0_if.t_valid, s0_if.t_data, s1_if.t_valid, s1_if.t_data);
        else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++;
        if (s0_if.t_valid !== 1'b0 || s1_if.t_valid !== 1'b0)
            $display("FAIL stl_drained got v0=%b v1=%b expected 0 0", s0_if.t_valid, s1_if.t_valid);
        else n_pass++;
    endtask

    task automatic test_stall_stable();
        tb_beat_t b;
        s0_if.t_ready = 1'b0;
        s1_if.t_ready = 1'b1;
        @(posedge clk);
        #1;
        b = make_beat(3);
        b.data = 8'hC3;
        b.last = 1'b1;
        b.user = 3'd5;
        drive(b);
        m_if.t_valid = 1'b1;
        @(posedge clk);
        #1;
        m_if.t_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (s0_if.t_valid !== 1'b1 || s0_if.t_data !== 8'hC3 || s0_if.t_last !== 1'b1 || s0_if.t_user !== 3'd5)
                $display("FAIL stable[%0d] got v=%b d=%h l=%b u=%0d expected v=1 d=c3 l=1 u=5",
                         k, s0_if.t_valid, s0_if.t_data, s0_if.t_last, s0_if.t_user);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        s0_if.t_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++;
        if (s0_if.t_valid !== 1'b0) $display("FAIL stable_done got %b expected 0", s0_if.t_valid);
        else n_pass++;
    endtask

    task automatic test_random(input int n);
        int idx   = 0;
        int guard = 0;
        logic acc = 1'b0;
        n_del0 = 0;
        n_del1 = 0;
        while (idx < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
            if (acc) idx++;
            if (idx < n) begin
                if (acc || !m_if.t_valid) m_if.t_valid = ($urandom_range(0, 3) != 0);
                drive(make_beat(idx));
            end else begin
                m_if.t_valid = 1'b0;
            end
            s0_if.t_ready = $urandom_range(0, 1) == 1;
            s1_if.t_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            acc = m_if.t_valid && m_if.t_ready;
        end
        n_total++;
        if (idx !== n) $display("FAIL rnd_sent got %0d expected %0d", idx, n);
        else n_pass++;
        @(posedge clk);
        #1;
        s0_if.t_ready = 1'b1;
        s1_if.t_ready = 1'b1;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_total++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL rnd_drain got q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
        else n_pass++;
        n_total++;
        if (n_del0 !== n || n_del1 !== n)
            $display("FAIL rnd_count got s0=%0d s1=%0d expected %0d", n_del0, n_del1, n);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        s0_if.t_ready = 1'b1;
        s1_if.t_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(make_beat(7));
        m_if.t_valid = 1'b1;
        @(posedge clk);
        #1;
        m_if.t_valid = 1'b0;
        @(posedge clk);
        #2;
        n_total++;
        if (s0_if.t_valid !== 1'b0 || s1_if.t_valid !== 1'b1)
            $display("FAIL mid_pre got v0=%b v1=%b expected 0 1", s0_if.t_valid, s1_if.t_valid);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++;
        if (s0_if.t_valid !== 1'b0 || s1_if.t_valid !== 1'b0)
            $display("FAIL mid_async got v0=%b v1=%b expected 0 0", s0_if.t_valid, s1_if.t_valid);
        else n_pass++;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        s1_if.t_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (s0_if.t_valid !== 1'b0 || s1_if.t_valid !== 1'b0 || m_if.t_ready !== 1'b1)
                $display("FAIL mid_after[%0d] got v0=%b v1=%b rdy=%b expected 0 0 1",
                         k, s0_if.t_valid, s1_if.t_valid, m_if.t_ready);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

`ifdef STREAM_FORK_STATS_EN
    task automatic test_stats();
        m_if.t_valid = 1'b0;
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        n_total++;
        if (pkt_count !== 32'd0 || beat_count !== 32'd0)
            $display("FAIL stats_rst got pkt=%0d beat=%0d expected 0 0", pkt_count, beat_count);
        else n_pass++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        s0_if.t_ready = 1'b1;
        s1_if.t_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            drive(make_beat(i));
            m_if.t_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        m_if.t_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (pkt_count !== 32'd3 || beat_count !== 32'd12)
            $display("FAIL stats_count got pkt=%0d beat=%0d expected 3 12", pkt_count, beat_count);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rstn          = 1'b0;
        m_if.t_valid  = 1'b0;
        drive('0);
        s0_if.t_ready = 1'b0;
        s1_if.t_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_one_stalled();
        test_stall_stable();
        test_random(1000);
        test_reset_mid();
`ifdef STREAM_FORK_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
